// File: rtl/line_window_gen_pkg.sv
// Shared constants for the 3x3 window bus: element indices and packing width.
// Imported by the window generator and available to the downstream sharpen MAC.
package line_window_gen_pkg;

    localparam int WINDOW_ELEMS  = 9;

    localparam int TOP_LEFT      = 0;
    localparam int TOP_CENTER    = 1;
    localparam int TOP_RIGHT     = 2;
    localparam int MID_LEFT      = 3;
    localparam int CENTER        = 4;
    localparam int MID_RIGHT     = 5;
    localparam int BOTTOM_LEFT   = 6;
    localparam int BOTTOM_CENTER = 7;
    localparam int BOTTOM_RIGHT  = 8;

    typedef enum logic {
        PHASE_FILL,
        PHASE_RUN
    } phaseT;

    function automatic int windowWidth(input int dataWidth);
        return WINDOW_ELEMS * dataWidth;
    endfunction

endpackage

// File: rtl/line_window_gen_line_buffer.sv
// One image line of storage: synchronous write, asynchronous read, so a read
// and a write to the same address on one edge return the old contents.
module line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 512,
    localparam int ADDR_W    = $clog2(IMG_WIDTH)
) (
    input  logic                  clk,
    input  logic                  wrEn,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic [DATA_WIDTH-1:0] rdData
);

    logic [DATA_WIDTH-1:0] mem [IMG_WIDTH];

    // Contents are deliberately not reset; the row gating upstream never exposes stale lines.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[addr] <= wrData;
        end
    end

    assign rdData = mem[addr];

endmodule

// File: rtl/line_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, packed interior windows out
// one cycle later, with a pulse on the last window of each frame.
module line_window_gen
    import line_window_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              inPixel,
    input  logic                               inPixelValid,
    output logic [WINDOW_ELEMS*DATA_WIDTH-1:0] outWindow,
    output logic                               outWindowValid,
    output logic                               outFrameDone
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDTH-1:0] lineTop;
    logic [DATA_WIDTH-1:0] lineMid;
    logic [DATA_WIDTH-1:0] win [WINDOW_ELEMS];
    logic                  accept;
    logic                  lastCol;
    logic                  lastRow;
    logic                  winHit;
    phaseT                 phase;

    assign accept  = inPixelValid && !rst;
    assign lastCol = (col == COL_W'(IMG_WIDTH - 1));
    assign lastRow = (row == ROW_W'(IMG_HEIGHT - 1));
    assign phase   = (row >= ROW_W'(2)) ? PHASE_RUN : PHASE_FILL;
    // Columns 0 and 1 of every line only prime the shift register.
    assign winHit  = (phase == PHASE_RUN) && (col >= COL_W'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (inPixelValid) begin
            if (lastCol) begin
                col <= '0;
                row <= lastRow ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // lbA holds line row-1; lbB holds line row-2 and is fed from lbA's old value.
    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_WIDTH  (IMG_WIDTH)
    ) lbA (
        .clk    (clk),
        .wrEn   (accept),
        .addr   (col),
        .wrData (inPixel),
        .rdData (lineMid)
    );

    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_WIDTH  (IMG_WIDTH)
    ) lbB (
        .clk    (clk),
        .wrEn   (accept),
        .addr   (col),
        .wrData (lineMid),
        .rdData (lineTop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WINDOW_ELEMS; i++) begin
                win[i] <= '0;
            end
        end else if (inPixelValid) begin
            for (int r = 0; r < 3; r++) begin
                win[3*r]     <= win[3*r + 1];
                win[3*r + 1] <= win[3*r + 2];
            end
            win[TOP_RIGHT]    <= lineTop;
            win[MID_RIGHT]    <= lineMid;
            win[BOTTOM_RIGHT] <= inPixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outWindowValid <= 1'b0;
            outFrameDone   <= 1'b0;
        end else begin
            outWindowValid <= inPixelValid && winHit;
            outFrameDone   <= inPixelValid && winHit && lastRow && lastCol;
        end
    end

    always_comb begin
        outWindow = '0;
        for (int i = 0; i < WINDOW_ELEMS; i++) begin
            outWindow[i*DATA_WIDTH +: DATA_WIDTH] = win[i];
        end
    end

endmodule

// File: tb/tb_line_window_gen.sv
// Bench for line_window_gen on a 5x4 image: an image-array reference model checks
// every output cycle, plus spot tables and counts for the listed scenarios.
module tb_line_window_gen;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int WW = 9 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] inPixel = '0;
    logic          inPixelValid = 1'b0;
    logic [WW-1:0] outWindow;
    logic          outWindowValid;
    logic          outFrameDone;

    int checks = 0;
    int errors = 0;

    line_window_gen #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inPixel        (inPixel),
        .inPixelValid   (inPixelValid),
        .outWindow      (outWindow),
        .outWindowValid (outWindowValid),
        .outFrameDone   (outFrameDone)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: the frame is kept as a 2-D image; a window is the 3x3
    // neighbourhood ending at the accepted pixel, read straight from that image.
    logic [DW-1:0] img [H][W];
    int            nPix = 0;
    int            mRow;
    int            mCol;
    logic          mValid = 1'b0;
    logic          mDone = 1'b0;
    logic          holdValid = 1'b0;
    logic [WW-1:0] mWin = '0;

    always_comb begin
        mRow = nPix / W;
        mCol = nPix % W;
    end

    function automatic logic [WW-1:0] windowAt(input int r, input int c, input logic [DW-1:0] p);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (i == 2 && j == 2) w[(3*i+j)*DW +: DW] = p;
                else                  w[(3*i+j)*DW +: DW] = img[r-2+i][c-2+j];
            end
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            nPix      <= 0;
            mValid    <= 1'b0;
            mDone     <= 1'b0;
            mWin      <= '0;
            holdValid <= 1'b1;
        end else if (inPixelValid) begin
            img[mRow][mCol] <= inPixel;
            mValid    <= (mRow >= 2 && mCol >= 2);
            mDone     <= (mRow == H-1 && mCol == W-1);
            holdValid <= (mRow >= 2 && mCol >= 2);
            if (mRow >= 2 && mCol >= 2) mWin <= windowAt(mRow, mCol, inPixel);
            nPix <= (nPix + 1) % (W * H);
        end else begin
            mValid <= 1'b0;
            mDone  <= 1'b0;
        end
    end

    logic [WW-1:0] winLog [64];
    int            winCount = 0;
    int            doneCount = 0;
    int            doneIdx = -1;

    always @(negedge clk) begin
        checkVal("outWindowValid", {71'b0, outWindowValid}, {71'b0, mValid});
        checkVal("outFrameDone", {71'b0, outFrameDone}, {71'b0, mDone});
        if (mValid || holdValid) checkVal("outWindow", outWindow, mWin);
        if (outWindowValid) begin
            if (winCount < 64) winLog[winCount] = outWindow;
            if (outFrameDone) begin
                doneCount++;
                doneIdx = winCount;
            end
            winCount++;
        end
    end

    task automatic clearLog();
        winCount  = 0;
        doneCount = 0;
        doneIdx   = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mode 0: row*16+col, 1: 0xFF-(row*16+col), 2: uniform 0x40, 3: random
    task automatic runPixels(input int mode, input int gapPct, input int first, input int count);
        for (int k = first; k < first + count; k++) begin
            int r;
            int c;
            logic [DW-1:0] v;
            r = k / W;
            c = k % W;
            while (gapPct > 0 && $urandom_range(99) < gapPct) idle(1);
            case (mode)
                0:       v = DW'(r*16 + c);
                1:       v = 8'hFF - DW'(r*16 + c);
                2:       v = 8'h40;
                default: v = DW'($urandom);
            endcase
            inPixel = v;
            inPixelValid = 1'b1;
            @(posedge clk);
            #1;
            inPixelValid = 1'b0;
        end
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        int           winIdx;
        int           elem;
        logic [DW-1:0] exp;
    } spotT;

    spotT contSpots[10];
    spotT frame2Spots[3];

    task automatic checkContSpots(input int base, input string tag);
        for (int i = 0; i < 10; i++) begin
            checkVal($sformatf("%s w%0d e%0d", tag, contSpots[i].winIdx, contSpots[i].elem),
                     {64'b0, winLog[base + contSpots[i].winIdx][contSpots[i].elem*DW +: DW]},
                     {64'b0, contSpots[i].exp});
        end
    endtask

    task automatic checkCounts(input string tag, input int wins, input int dones, input int dIdx);
        checkVal({tag, " windows"}, WW'(winCount), WW'(wins));
        checkVal({tag, " frameDone count"}, WW'(doneCount), WW'(dones));
        checkVal({tag, " frameDone index"}, WW'(doneIdx), WW'(dIdx));
    endtask

    initial begin
        contSpots[0] = '{0, 0, 8'h00};
        contSpots[1] = '{0, 4, 8'h11};
        contSpots[2] = '{0, 8, 8'h22};
        contSpots[3] = '{0, 3, 8'h10};
        contSpots[4] = '{2, 2, 8'h04};
        contSpots[5] = '{2, 8, 8'h24};
        contSpots[6] = '{3, 0, 8'h10};
        contSpots[7] = '{3, 4, 8'h21};
        contSpots[8] = '{5, 0, 8'h12};
        contSpots[9] = '{5, 8, 8'h34};
        frame2Spots[0] = '{6, 0, 8'hFF};
        frame2Spots[1] = '{6, 4, 8'hEE};
        frame2Spots[2] = '{6, 8, 8'hDD};

        idle(2);
        checkVal("reset outWindow", outWindow, '0);
        checkVal("reset row/col", {64'b0, 6'(dut.row), 2'b0}, '0);
        rst = 1'b0;

        // Continuous frame
        clearLog();
        runPixels(0, 0, 0, W*H);
        idle(3);
        checkCounts("continuous", 6, 1, 5);
        checkContSpots(0, "continuous");

        // Same frame with ~50% input gaps
        clearLog();
        runPixels(0, 50, 0, W*H);
        idle(3);
        checkCounts("gapped", 6, 1, 5);
        checkContSpots(0, "gapped");

        // Two back-to-back frames, second inverted
        clearLog();
        runPixels(0, 0, 0, W*H);
        runPixels(1, 0, 0, W*H);
        idle(3);
        checkCounts("b2b", 12, 2, 11);
        for (int i = 0; i < 3; i++) begin
            checkVal($sformatf("b2b frame2 e%0d", frame2Spots[i].elem),
                     {64'b0, winLog[frame2Spots[i].winIdx][frame2Spots[i].elem*DW +: DW]},
                     {64'b0, frame2Spots[i].exp});
        end

        // Reset after pixel (2,3), then restart the frame
        clearLog();
        runPixels(0, 0, 0, 2*W + 4);
        idle(1);
        resetPulse();
        runPixels(0, 0, 0, W*H);
        idle(3);
        checkCounts("midreset", 8, 1, 7);
        checkContSpots(2, "midreset");

        // Reset coincident with a valid pixel: pixel dropped, state zeroed
        clearLog();
        runPixels(0, 0, 0, 7);
        rst = 1'b1;
        inPixel = 8'h99;
        inPixelValid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        inPixelValid = 1'b0;
        checkVal("rst+valid col", WW'(dut.col), '0);
        checkVal("rst+valid row", WW'(dut.row), '0);
        checkVal("rst+valid outWindow", outWindow, '0);
        checkVal("rst+valid flags", {70'b0, outWindowValid, outFrameDone}, '0);
        clearLog();
        runPixels(0, 0, 0, W*H);
        idle(3);
        checkCounts("after rst+valid", 6, 1, 5);
        checkContSpots(0, "after rst+valid");

        // Uniform image: every window is flat, so a sharpen kernel returns 0x40
        clearLog();
        runPixels(2, 0, 0, W*H);
        idle(3);
        checkCounts("uniform", 6, 1, 5);
        for (int i = 0; i < 6; i++) begin
            checkVal($sformatf("uniform w%0d", i), winLog[i], {9{8'h40}});
        end

        // Random pixel values and gaps across two frames
        clearLog();
        runPixels(3, 40, 0, W*H);
        runPixels(3, 40, 0, W*H);
        idle(3);
        checkCounts("random", 12, 2, 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: run did not complete, got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
